// File: rtl/header_stream_arbiter.sv
// Round-robin arbiter merging per-port header + AXI-Stream pairs into one stream.
// Each grant carries exactly one header and one full packet, ending on tlast.
module header_stream_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 128,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = 64,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8,
    parameter int SEL_WIDTH  = $clog2(PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS*STRB_WIDTH-1:0]   s_axis_tkeep,
    input  logic [PORTS*DEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
    input  logic [PORTS-1:0]              s_axis_tlast,
    input  logic [PORTS-1:0]              s_axis_tvalid,
    output logic [PORTS-1:0]              s_axis_tready,
    input  logic [PORTS*HDR_WIDTH-1:0]    s_hdr,
    input  logic [PORTS-1:0]              s_hdr_valid,
    output logic [PORTS-1:0]              s_hdr_ready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [STRB_WIDTH-1:0]         m_axis_tkeep,
    output logic [DEST_WIDTH-1:0]         m_axis_tdest,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [HDR_WIDTH-1:0]          m_hdr,
    output logic                          m_hdr_valid,
    input  logic                          m_hdr_ready,
    input  logic [PORTS-1:0]              port_enable,
    output logic                          busy,
    output logic [SEL_WIDTH-1:0]          grant_idx
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] grant_q, grant_d;
    logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;
    logic                 hdr_pending_q, hdr_pending_d;
    logic [PORTS-1:0]     cand_s;
    logic                 hdr_xfer_s;
    logic                 last_xfer_s;

    // First candidate after the previous winner, wrapping modulo PORTS.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [PORTS-1:0]     cand,
                                                     input logic [SEL_WIDTH-1:0] last);
        logic [SEL_WIDTH-1:0] pick;
        logic [SEL_WIDTH-1:0] idx;
        logic                 found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= PORTS; k++) begin
            idx = SEL_WIDTH'((32'(last) + k) % PORTS);
            if (!found && cand[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
            found = found | cand[idx];
        end
        return pick;
    endfunction

    assign cand_s      = s_axis_tvalid & s_hdr_valid & port_enable;
    assign hdr_xfer_s  = m_hdr_valid & m_hdr_ready;
    assign last_xfer_s = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // State, grant and header-pending registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= SEL_WIDTH'(PORTS - 1);
            hdr_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            hdr_pending_q <= hdr_pending_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, track header and tlast in BUSY.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        hdr_pending_d = hdr_pending_q;
        case (state_q)
            IDLE: begin
                if (|cand_s) begin
                    grant_d       = rr_pick(cand_s, last_grant_q);
                    hdr_pending_d = 1'b1;
                    state_d       = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (hdr_xfer_s) begin
                    hdr_pending_d = 1'b0;
                end else begin
                    hdr_pending_d = hdr_pending_q;
                end
                // A one-word packet completes header and tlast together.
                if (last_xfer_s) begin
                    state_d       = IDLE;
                    last_grant_d  = grant_q;
                    hdr_pending_d = 1'b0;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mux: granted port routed through in BUSY, everything quiet otherwise.
    always_comb begin
        s_axis_tready = '0;
        s_hdr_ready   = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tdest  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_hdr         = '0;
        m_hdr_valid   = 1'b0;
        busy          = 1'b0;
        grant_idx     = '0;
        if (!rst) begin
            grant_idx = grant_q;
            if (state_q == BUSY) begin
                busy                   = 1'b1;
                m_axis_tdata           = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tkeep           = s_axis_tkeep[grant_q*STRB_WIDTH +: STRB_WIDTH];
                m_axis_tdest           = s_axis_tdest[grant_q*DEST_WIDTH +: DEST_WIDTH];
                m_axis_tuser           = s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
                m_axis_tlast           = s_axis_tlast[grant_q];
                m_axis_tvalid          = s_axis_tvalid[grant_q];
                s_axis_tready[grant_q] = m_axis_tready;
                m_hdr                  = s_hdr[grant_q*HDR_WIDTH +: HDR_WIDTH];
                m_hdr_valid            = s_hdr_valid[grant_q] & hdr_pending_q;
                s_hdr_ready[grant_q]   = hdr_pending_q & m_hdr_ready;
            end else begin
                busy = 1'b0;
            end
        end else begin
            grant_idx = '0;
        end
    end

endmodule

// File: doc/header_stream_arbiter.md
HEADER_STREAM_ARBITER -- requirements
Module: header_stream_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesters (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 128: tdata width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: tkeep width.
REQ-004 SHALL have parameter HDR_WIDTH, default 64: header width.
REQ-005 SHALL have parameter DEST_WIDTH, default 8, and USER_WIDTH, default 8: tdest and tuser widths.
REQ-006 SHALL have parameter SEL_WIDTH, default $clog2(PORTS): grant index width.
REQ-007 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port s_axis_tdata, input, PORTS*DATA_WIDTH: per-port data, port i at slice i.
REQ-010 SHALL have ports s_axis_tkeep (PORTS*STRB_WIDTH), s_axis_tdest (PORTS*DEST_WIDTH), s_axis_tuser (PORTS*USER_WIDTH), s_axis_tlast (PORTS) and s_axis_tvalid (PORTS), all inputs: per-port AXI-Stream sideband.
REQ-011 SHALL have port s_axis_tready, output, PORTS: per-port ready.
REQ-012 SHALL have port s_hdr, input, PORTS*HDR_WIDTH: per-port header.
REQ-013 SHALL have ports s_hdr_valid, input, PORTS, and s_hdr_ready, output, PORTS: per-port header handshake.
REQ-014 SHALL have ports m_axis_tdata, m_axis_tkeep, m_axis_tdest, m_axis_tuser, m_axis_tlast and m_axis_tvalid as outputs, and m_axis_tready as input, 1: merged stream feeding the header adder.
REQ-015 SHALL have ports m_hdr, output, HDR_WIDTH; m_hdr_valid, output, 1; and m_hdr_ready, input, 1: merged header handshake.
REQ-016 SHALL have port port_enable, input, PORTS: a port is eligible only while its bit is 1.
REQ-017 SHALL have ports busy, output, 1, and grant_idx, output, SEL_WIDTH: arbiter status.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and BUSY, with IDLE as the reset state.
REQ-019 In IDLE, port i SHALL be a candidate iff s_axis_tvalid[i] && s_hdr_valid[i] && port_enable[i].
REQ-020 In IDLE with at least one candidate, the block SHALL register as grant the first candidate found scanning round-robin from last_grant+1 (wrapping modulo PORTS), set hdr_pending=1, and enter BUSY on the next edge.
REQ-021 Arbitration latency SHALL be one cycle: in IDLE all s_axis_tready, s_hdr_ready, m_axis_tvalid and m_hdr_valid outputs SHALL be 0.
REQ-022 In BUSY, the m_axis_* outputs SHALL equal the granted port's slices combinationally, s_axis_tready[grant] SHALL equal m_axis_tready, and all other tready bits SHALL be 0.
REQ-023 In BUSY, m_hdr SHALL equal s_hdr[grant], and m_hdr_valid SHALL equal s_hdr_valid[grant] && hdr_pending.
REQ-024 s_hdr_ready[grant] SHALL equal hdr_pending && m_hdr_ready, and all other s_hdr_ready bits SHALL be 0.
REQ-025 hdr_pending SHALL clear on m_hdr_valid && m_hdr_ready, so exactly one header is passed per packet.
REQ-026 On m_axis_tvalid && m_axis_tready && m_axis_tlast in BUSY, the block SHALL go to IDLE, set last_grant=grant and clear hdr_pending.
REQ-027 A header and tlast handshake in the same cycle (one-word packet) SHALL both complete.
REQ-028 Deasserting port_enable[grant] mid-packet SHALL NOT abort the packet; the change SHALL affect only subsequent arbitration.
REQ-029 busy SHALL be 1 exactly in BUSY, and grant_idx SHALL hold the registered grant, including the last value while in IDLE.
REQ-030 With a candidate present, at most one idle cycle SHALL separate back-to-back packets.
REQ-031 If no candidate is present, the block SHALL remain in IDLE with no change to last_grant.
REQ-032 Fairness: with all PORTS ports continuously requesting, each port SHALL be granted exactly once per PORTS packets.

Reset
REQ-033 On rst=1 at a clock edge, the block SHALL set state=IDLE, grant=0, last_grant=PORTS-1 (port 0 first priority) and hdr_pending=0.
REQ-034 During reset, all outputs SHALL be 0, including the m_axis_* data outputs.
REQ-035 Reset asserted mid-packet SHALL abandon the packet without emitting tlast; upstream is reset with the block.

Verification
REQ-036 The bench SHALL cover: after reset, ports 0 and 2 request simultaneously -> port 0 is granted first, then port 2; grant_idx=0 then 2.
REQ-037 The bench SHALL cover: all 4 ports stream continuously for 8 packets -> grant order 0,1,2,3,0,1,2,3.
REQ-038 The bench SHALL cover: a one-word packet on port 1 (tlast=1, header valid) with m_hdr_ready=m_axis_tready=1 -> header and data transfer in the same cycle, followed by IDLE on the next cycle.
REQ-039 The bench SHALL cover: a 3-word packet on port 3 with m_axis_tready toggled 1,0,1,0,1 -> exactly 3 beats, no other port's tready is ever 1, and m_hdr_valid is high only before the first header handshake.
REQ-040 The bench SHALL cover: port_enable=4'b1110 with port 0 requesting -> port 0 is never granted; port_enable[2] cleared mid-packet on port 2 -> that packet still completes.
REQ-041 The bench SHALL cover: rst asserted on beat 2 of a 4-word packet -> next cycle busy=0, all readies 0, and port 0 has priority on restart.
